// File: rtl/uart_pkg.sv
// Shared UART receive-side types and constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RECV  = 2'd2,
    ST_DRAIN = 2'd3
  } rx_ctrl_state_t;

  localparam int unsigned UART_FRAME_BITS  = 10;
  localparam logic [15:0] UART_DEFAULT_DIV = 16'd10417;
  localparam int unsigned ERR_CNT_W        = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO, first-word fall-through; a pop frees room for a push in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [7:0]               i_wdata,
  output logic [7:0]               o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_pop    = i_pop & ~w_empty;
  assign w_push   = i_push & (~w_full | w_pop);
  // A byte is lost only when full with no pop; a flush discards it silently.
  assign o_drop_c = i_push & w_full & ~w_pop & ~i_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= 8'h00;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: rx_en sequencing, byte FIFO, error/overrun status.
// Optional idle timeout built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] DIV      = UART_DEFAULT_DIV,
  parameter int unsigned TO_CHARS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   clr_status,
  output logic                   rx_en,
  input  logic                   rx_busy,
  input  logic                   rx_done,
  input  logic                   rx_error,
  input  logic [7:0]             rx_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   timeout
);

  rx_ctrl_state_t r_state;
  logic           w_done;
  logic           w_err;
  logic           w_push_req;
  logic           w_pop;
  logic           w_drop;

  // Frames completing while idle (e.g. straggling after reset) are ignored.
  assign w_done     = rx_done & (r_state != ST_IDLE);
  assign w_err      = w_done & rx_error;
  assign w_push_req = w_done & ~rx_error;
  assign rd_valid   = (level != '0);
  assign w_pop      = rd_valid & rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      rx_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_ARMED;
            rx_en   <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            rx_en   <= 1'b0;
          end else if (rx_busy) begin
            r_state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (rx_done || !rx_busy) r_state <= ST_ARMED;
          else if (!enable)        r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rx_done || !rx_busy) begin
            r_state <= ST_IDLE;
            rx_en   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          rx_en   <= 1'b0;
        end
      endcase
    end
  end

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push_req),
    .i_pop    (rd_ready),
    .i_flush  (flush),
    .i_wdata  (rx_data),
    .o_rdata  (rd_data),
    .o_level  (level),
    .o_drop_c (w_drop)
  );

  // Status: a new event in the same cycle as clr_status takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (w_drop)          overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;

      if (w_err) begin
        if (clr_status)              err_count <= ERR_CNT_W'(1);
        else if (err_count != '1)    err_count <= err_count + ERR_CNT_W'(1);
      end else if (clr_status) begin
        err_count <= '0;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [19:0] TO_LIMIT = 20'(TO_CHARS * UART_FRAME_BITS * 32'(DIV));

  logic [19:0] r_to_cnt;
  logic        w_to_rst;
  logic        w_to_hit;

  assign w_to_rst = w_push_req | w_pop | flush | rx_busy;
  assign w_to_hit = ~w_to_rst & rd_valid & (r_to_cnt == TO_LIMIT - 20'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (w_to_rst || !rd_valid) r_to_cnt <= '0;
      else if (r_to_cnt != '1)   r_to_cnt <= r_to_cnt + 20'd1;

      if (w_to_hit)        timeout <= 1'b1;
      else if (clr_status) timeout <= 1'b0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{DIV, 32'(TO_CHARS)};
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=4, DIV=16, TO_CHARS=4).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       flush;
  logic       clr_status;
  logic       rx_en;
  logic       rx_busy;
  logic       rx_done;
  logic       rx_error;
  logic [7:0] rx_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [2:0] level;
  logic       overrun;
  logic [7:0] err_count;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(4), .DIV(16'd16), .TO_CHARS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .clr_status (clr_status),
    .rx_en      (rx_en),
    .rx_busy    (rx_busy),
    .rx_done    (rx_done),
    .rx_error   (rx_error),
    .rx_data    (rx_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .level      (level),
    .overrun    (overrun),
    .err_count  (err_count),
    .timeout    (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic err);
    rx_done  = 1'b1;
    rx_error = err;
    rx_data  = d;
    tick();
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; clr_status = 1'b0;
    rx_busy = 1'b0; rx_done = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_rx_en", rx_en, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_level", level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err_count", err_count, 0);
    check("rst_timeout", timeout, 0);

    // basic push / fall-through / pop
    enable = 1'b1;
    tick();
    check("arm_rx_en", rx_en, 1);
    send(8'hA5, 1'b0);
    check("push1_valid", rd_valid, 1);
    check("push1_data", rd_data, 8'hA5);
    send(8'h3C, 1'b0);
    check("push2_level", level, 2);
    check("push2_head", rd_data, 8'hA5);
    pop_one();
    check("pop1_data", rd_data, 8'h3C);
    check("pop1_level", level, 1);
    pop_one();
    check("pop2_level", level, 0);
    check("pop2_valid", rd_valid, 0);
    pop_one();
    check("pop_empty_level", level, 0);

    // overrun on fifth byte
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    check("ovr_level", level, 4);
    check("ovr_flag", overrun, 1);
    pulse_clr();
    check("ovr_clr", overrun, 0);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_contents", rd_data, 32'(i));
      pop_one();
    end
    check("ovr_drained", level, 0);

    // full FIFO, push and pop in the same cycle
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("full_level", level, 4);
    rd_ready = 1'b1;
    send(8'hFF, 1'b0);
    rd_ready = 1'b0;
    check("fullpp_level", level, 4);
    check("fullpp_overrun", overrun, 0);
    check("fullpp_head", rd_data, 8'h22);
    pop_one(); pop_one(); pop_one();
    check("fullpp_last", rd_data, 8'hFF);
    pop_one();
    check("fullpp_drained", level, 0);

    // framing errors
    for (int i = 0; i < 3; i++) send(8'hEE, 1'b1);
    check("err3_level", level, 0);
    check("err3_count", err_count, 3);
    for (int i = 0; i < 297; i++) send(8'hEE, 1'b1);
    check("err_sat", err_count, 255);
    clr_status = 1'b1;
    send(8'hEE, 1'b1);
    clr_status = 1'b0;
    check("err_clr_wins", err_count, 1);
    pulse_clr();
    check("err_clr", err_count, 0);

    // flush drops a coincident byte without overrun
    send(8'h55, 1'b0); send(8'h66, 1'b0);
    flush = 1'b1;
    send(8'h77, 1'b0);
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_overrun", overrun, 0);
    send(8'h88, 1'b0);
    check("post_flush_data", rd_data, 8'h88);
    check("post_flush_level", level, 1);
    pop_one();

    // disable deferred until end of frame
    rx_busy = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    check("drain_rx_en_a", rx_en, 1);
    tick();
    check("drain_rx_en_b", rx_en, 1);
    send(8'h96, 1'b0);
    check("drain_done_rx_en", rx_en, 0);
    check("drain_level", level, 1);
    check("drain_data", rd_data, 8'h96);
    rx_busy = 1'b0;
    pop_one();

    // reset mid-frame, coincident rx_done ignored
    enable = 1'b1;
    tick();
    rx_busy = 1'b1;
    tick();
    send(8'h5A, 1'b0);
    check("pre_rst_level", level, 1);
    tick();
    rst = 1'b1; rx_done = 1'b1; rx_data = 8'hC3;
    tick();
    check("rst_mid_rx_en", rx_en, 0);
    check("rst_mid_level", level, 0);
    rst = 1'b0; rx_done = 1'b0; rx_busy = 1'b0;
    tick();
    check("rst_mid_level_after", level, 0);
    check("rearm_rx_en", rx_en, 1);

`ifdef UART_RX_TIMEOUT_EN
    // 4 chars * 10 bits * 16 clocks = 640 idle clocks
    send(8'h42, 1'b0);
    repeat (639) tick();
    check("to_before", timeout, 0);
    tick();
    check("to_set", timeout, 1);
    pop_one();
    pulse_clr();
    check("to_clr", timeout, 0);
    send(8'h43, 1'b0);
    repeat (599) tick();
    pop_one();
    repeat (100) tick();
    check("to_pop_restart", timeout, 0);
`else
    send(8'h42, 1'b0);
    repeat (700) tick();
    check("to_tied_low", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
